// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// The master side is fetch plus decode; the slave side is the buffer.
interface if_id_buffer_if;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc2;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc2;
    logic        halted;

    modport master (
        output if_valid, if_instr, if_pc2,
        output flush, id_ready,
        input  if_ready, id_valid, id_instr,
        input  id_pc2, halted
    );

    modport slave (
        input  if_valid, if_instr, if_pc2,
        input  flush, id_ready,
        output if_ready, id_valid, id_instr,
        output id_pc2, halted
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer: a head register and a skid register.
// Outputs come only from registers, and a popped HALT word parks the block.
module if_id_buffer #(
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input logic           clk,
    input logic           rst,
    if_id_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ONE    = 2'd1,
        FULL   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [15:0] head_instr_q, head_instr_d;
    logic [15:0] head_pc2_q, head_pc2_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;

    logic        head_valid;
    logic        push;
    logic        pop;
    logic        halt_pop;

    assign head_valid = (state_q == ONE) || (state_q == FULL);
    assign push       = bus.if_valid && ready_q;
    assign pop        = head_valid && bus.id_ready;
    assign halt_pop   = pop && (head_instr_q[15:11] == HALT_OPCODE);

    assign bus.if_ready = ready_q;
    assign bus.id_valid = head_valid;
    assign bus.id_instr = head_valid ? head_instr_q : NOP_INSTR;
    assign bus.id_pc2   = head_valid ? head_pc2_q : 16'h0000;
    assign bus.halted   = (state_q == HALTED);

    // Next state and entry contents; halt beats flush, flush beats push/pop.
    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc2_d   = head_pc2_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;

        if (state_q != HALTED) begin
            if (halt_pop || bus.flush) begin
                state_d      = halt_pop ? HALTED : EMPTY;
                head_instr_d = 16'h0000;
                head_pc2_d   = 16'h0000;
                skid_instr_d = 16'h0000;
                skid_pc2_d   = 16'h0000;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            state_d      = ONE;
                            head_instr_d = bus.if_instr;
                            head_pc2_d   = bus.if_pc2;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_instr_d = bus.if_instr;
                            head_pc2_d   = bus.if_pc2;
                        end else if (push) begin
                            state_d      = FULL;
                            skid_instr_d = bus.if_instr;
                            skid_pc2_d   = bus.if_pc2;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state_d      = ONE;
                            head_instr_d = skid_instr_q;
                            head_pc2_d   = skid_pc2_q;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        ready_d = (state_d == EMPTY) || (state_d == ONE);
    end

    // State, ready flag and both entries; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            ready_q      <= 1'b1;
            head_instr_q <= 16'h0000;
            head_pc2_q   <= 16'h0000;
            skid_instr_q <= 16'h0000;
            skid_pc2_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            head_instr_q <= head_instr_d;
            head_pc2_q   <= head_pc2_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_if_id_buffer;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    if_id_buffer_if bus ();

    if_id_buffer #(
        .NOP_INSTR  (16'h0800),
        .HALT_OPCODE(5'b00000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {15'd0, bus.id_valid}, 16'd0);
        check({tag, "_instr"}, bus.id_instr, 16'h0800);
        check({tag, "_pc2"}, bus.id_pc2, 16'h0000);
        check({tag, "_ready"}, {15'd0, bus.if_ready}, 16'd1);
        check({tag, "_halted"}, {15'd0, bus.halted}, 16'd0);
    endtask

    task automatic drive(input logic v, input logic [15:0] ins,
                         input logic [15:0] pc, input logic rdy,
                         input logic fl);
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc2   = pc;
        bus.id_ready = rdy;
        bus.flush    = fl;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_reset("reset");

        // streaming
        drive(1'b1, 16'h4001, 16'h0002, 1'b1, 1'b0);
        tick();
        check("s1_valid", {15'd0, bus.id_valid}, 16'd1);
        check("s1_instr", bus.id_instr, 16'h4001);
        check("s1_pc2", bus.id_pc2, 16'h0002);
        drive(1'b1, 16'h4002, 16'h0004, 1'b1, 1'b0);
        tick();
        check("s2_instr", bus.id_instr, 16'h4002);
        check("s2_valid", {15'd0, bus.id_valid}, 16'd1);
        drive(1'b1, 16'h4003, 16'h0006, 1'b1, 1'b0);
        tick();
        check("s3_instr", bus.id_instr, 16'h4003);
        check("s3_pc2", bus.id_pc2, 16'h0006);
        check("s3_ready", {15'd0, bus.if_ready}, 16'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        check("s4_valid", {15'd0, bus.id_valid}, 16'd0);
        check("s4_instr", bus.id_instr, 16'h0800);
        check("s4_pc2", bus.id_pc2, 16'h0000);

        // backpressure, with PC+2 wrap carried through
        drive(1'b1, 16'hA000, 16'hFFFE, 1'b0, 1'b0);
        tick();
        check("b1_instr", bus.id_instr, 16'hA000);
        check("b1_ready", {15'd0, bus.if_ready}, 16'd1);
        drive(1'b1, 16'hA001, 16'h0000, 1'b0, 1'b0);
        tick();
        check("b2_ready", {15'd0, bus.if_ready}, 16'd0);
        check("b2_instr", bus.id_instr, 16'hA000);
        check("b2_pc2", bus.id_pc2, 16'hFFFE);
        drive(1'b1, 16'hA002, 16'h0002, 1'b0, 1'b0);
        tick();
        check("b3_instr", bus.id_instr, 16'hA000);
        check("b3_ready", {15'd0, bus.if_ready}, 16'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        check("b4_instr", bus.id_instr, 16'hA001);
        check("b4_pc2", bus.id_pc2, 16'h0000);
        check("b4_valid", {15'd0, bus.id_valid}, 16'd1);
        check("b4_ready", {15'd0, bus.if_ready}, 16'd1);
        tick();
        check("b5_valid", {15'd0, bus.id_valid}, 16'd0);

        // flush in FULL with a concurrent push
        drive(1'b1, 16'hC000, 16'h0030, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hC001, 16'h0032, 1'b0, 1'b0);
        tick();
        check("f0_ready", {15'd0, bus.if_ready}, 16'd0);
        drive(1'b1, 16'hB000, 16'h0040, 1'b1, 1'b1);
        tick();
        check("f1_valid", {15'd0, bus.id_valid}, 16'd0);
        check("f1_instr", bus.id_instr, 16'h0800);
        check("f1_ready", {15'd0, bus.if_ready}, 16'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        check("f2_valid", {15'd0, bus.id_valid}, 16'd0);
        check("f2_instr", bus.id_instr, 16'h0800);

        // HALT held at the head is harmless
        drive(1'b1, 16'h0000, 16'h0020, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hh_halted", {15'd0, bus.halted}, 16'd0);
            check("hh_valid", {15'd0, bus.id_valid}, 16'd1);
            check("hh_pc2", bus.id_pc2, 16'h0020);
        end

        // pop the HALT
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        check("h1_halted", {15'd0, bus.halted}, 16'd1);
        check("h1_ready", {15'd0, bus.if_ready}, 16'd0);
        check("h1_valid", {15'd0, bus.id_valid}, 16'd0);
        check("h1_instr", bus.id_instr, 16'h0800);
        check("h1_pc2", bus.id_pc2, 16'h0000);
        drive(1'b1, 16'h4444, 16'h0050, 1'b1, 1'b1);
        tick();
        tick();
        check("h2_halted", {15'd0, bus.halted}, 16'd1);
        check("h2_valid", {15'd0, bus.id_valid}, 16'd0);
        check("h2_ready", {15'd0, bus.if_ready}, 16'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("h3");

        // HALT popped together with a flush still halts
        drive(1'b1, 16'h0123, 16'h0060, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        tick();
        check("hf_halted", {15'd0, bus.halted}, 16'd1);
        check("hf_ready", {15'd0, bus.if_ready}, 16'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("hf_rst");

        // reset while FULL, with everything else active
        drive(1'b1, 16'hD000, 16'h0070, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hD001, 16'h0072, 1'b0, 1'b0);
        tick();
        check("r0_ready", {15'd0, bus.if_ready}, 16'd0);
        drive(1'b1, 16'hD002, 16'h0074, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_reset("r1");
        tick();
        check_reset("r2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
